// File: rtl/ksa_sub_32_pipe.sv
// Pipelined unsigned subtractor: one WIDTH/STAGES-bit slice resolved per stage, borrow
// forwarded stage to stage, valid/ready handshake on both sides with collapsing bubbles.
module ksa_sub_32_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int W = WIDTH / STAGES;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] br_q;
  logic [STAGES-1:0] br_d;
  logic [STAGES-1:0] ready;
  logic [STAGES-1:0] load;

  logic [WIDTH-1:0] res_q [STAGES];
  logic [WIDTH-1:0] res_d [STAGES];
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opa_d [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] opb_d [STAGES];

  logic [W:0]       slice0;
  logic [W:0]       slice_k;

  // Ready ripples from the output back to the input; the only combinational path.
  always_comb begin
    ready = '0;
    ready[STAGES-1] = !v_q[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      ready[k] = !v_q[k] | ready[k+1];
    end
  end

  assign in_ready = ready[0];

  // Next-state for every stage: compute the stage's slice and splice it into the
  // result accumulated so far. Operands are forwarded whole; only the upper,
  // not-yet-consumed bits are ever read downstream.
  always_comb begin
    v_d     = '0;
    br_d    = '0;
    load    = '0;
    slice0  = '0;
    slice_k = '0;
    res_d   = '{default: '0};
    opa_d   = '{default: '0};
    opb_d   = '{default: '0};

    slice0   = {1'b0, a[W-1:0]} - {1'b0, b[W-1:0]};
    v_d[0]   = in_valid;
    load[0]  = ready[0] & in_valid;
    br_d[0]  = slice0[W];
    res_d[0][W-1:0] = slice0[W-1:0];
    opa_d[0] = a;
    opb_d[0] = b;

    for (int k = 1; k < STAGES; k++) begin
      slice_k  = {1'b0, opa_q[k-1][k*W +: W]}
               - {1'b0, opb_q[k-1][k*W +: W]}
               - {{W{1'b0}}, br_q[k-1]};
      v_d[k]   = v_q[k-1];
      load[k]  = ready[k] & v_q[k-1];
      br_d[k]  = slice_k[W];
      res_d[k] = res_q[k-1];
      res_d[k][k*W +: W] = slice_k[W-1:0];
      opa_d[k] = opa_q[k-1];
      opb_d[k] = opb_q[k-1];
    end
  end

  // Valid advances on ready alone; data only on ready with a valid source, so
  // bubbles never overwrite a held result.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q[gi]   <= 1'b0;
        br_q[gi]  <= 1'b0;
        res_q[gi] <= '0;
        opa_q[gi] <= '0;
        opb_q[gi] <= '0;
      end else begin
        if (ready[gi]) begin
          v_q[gi] <= v_d[gi];
        end
        if (load[gi]) begin
          br_q[gi]  <= br_d[gi];
          res_q[gi] <= res_d[gi];
          opa_q[gi] <= opa_d[gi];
          opb_q[gi] <= opb_d[gi];
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign d         = res_q[STAGES-1];
  assign bout      = br_q[STAGES-1];

endmodule

// File: tb/tb_ksa_sub_32_pipe.sv
// Directed and random checks of ksa_sub_32_pipe: latency, borrow ripple, backpressure,
// mid-stream reset, and an in-order scoreboard against {1'b0,a} - {1'b0,b}.
module tb_ksa_sub_32_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        bout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ksa_sub_32_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d        (d),
    .bout     (bout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: accept, confirm out_valid appears after exactly
  // STAGES-1 further edges, check the result, retire it.
  task automatic single(input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ed, input logic eb);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("single_in_ready a=%h", av), 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    tick();
    tick();
    @(negedge clk);
    chk($sformatf("latency_early a=%h", av), 64'(out_valid), 64'(0));
    tick();
    @(negedge clk);
    chk($sformatf("latency_valid a=%h", av), 64'(out_valid), 64'(1));
    chk($sformatf("single_d a=%h b=%h", av, bv), 64'(d), 64'(ed));
    chk($sformatf("single_bout a=%h b=%h", av, bv), 64'(bout), 64'(eb));
    tick();
  endtask

  logic [31:0] bp_a [6] = '{32'h0000_0010, 32'h0000_0100, 32'hFFFF_0000,
                            32'h0100_0000, 32'h0000_0000, 32'hDEAD_BEEF};
  logic [31:0] bp_b [6] = '{32'h0000_0001, 32'h0000_0200, 32'h0001_0000,
                            32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF};
  logic [31:0] bp_d [6] = '{32'h0000_000F, 32'hFFFF_FF00, 32'hFFFE_0000,
                            32'h00FF_FFFF, 32'h8000_0000, 32'h0000_0000};
  logic        bp_bo [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [32:0] q [$];
  logic [32:0] exp_r;

  initial begin
    int acc;
    int outs;
    int extra;
    int sent;
    int got;
    int cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_d", 64'(d), 64'(0));
    chk("reset_bout", 64'(bout), 64'(0));
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_reset_in_ready", 64'(in_ready), 64'(1));
    tick();

    // Directed single transactions
    single(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0);
    single(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
    single(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
    single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    single(32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    single(32'h1234_5678, 32'h00FF_00FF, 32'h1135_5579, 1'b0);
    single(32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0);

    // Backpressure: 6 pairs offered with the consumer stalled
    acc       = 0;
    outs      = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (acc < 6);
      a        = bp_a[(acc < 6) ? acc : 0];
      b        = bp_b[(acc < 6) ? acc : 0];
      @(negedge clk);
      if (out_valid) chk($sformatf("stall_d_stable c=%0d", c), 64'(d), 64'(bp_d[0]));
      if (in_valid && in_ready) acc++;
      tick();
    end
    @(negedge clk);
    chk("bp_accepted", 64'(acc), 64'(4));
    chk("bp_in_ready_full", 64'(in_ready), 64'(0));
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    chk("bp_head_d", 64'(d), 64'(bp_d[0]));
    tick();

    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (outs == 6) break;
      in_valid = (acc < 6);
      a        = bp_a[(acc < 6) ? acc : 0];
      b        = bp_b[(acc < 6) ? acc : 0];
      @(negedge clk);
      if (c == 0) chk("full_pass_in_ready", 64'(in_ready), 64'(1));
      if (out_valid) begin
        chk($sformatf("bp_d[%0d]", outs), 64'(d), 64'(bp_d[outs]));
        chk($sformatf("bp_bout[%0d]", outs), 64'(bout), 64'(bp_bo[outs]));
        outs++;
      end
      if (in_valid && in_ready) acc++;
      tick();
    end
    chk("bp_outputs", 64'(outs), 64'(6));
    chk("bp_all_accepted", 64'(acc), 64'(6));
    in_valid = 1'b0;
    extra    = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
      tick();
    end
    chk("bp_no_duplicate", 64'(extra), 64'(0));

    // Random back-to-back with in_valid/out_ready toggling
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 10000 && cyc < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
      a         = $urandom;
      b         = $urandom;
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious_output", 64'(out_valid), 64'(0));
        end else begin
          exp_r = q.pop_front();
          chk($sformatf("rand_result[%0d]", got), 64'({bout, d}), 64'(exp_r));
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({1'b0, a} - {1'b0, b});
        sent++;
      end
      tick();
      cyc++;
    end
    chk("rand_count", 64'(got), 64'(10000));
    chk("rand_queue_empty", 64'(q.size()), 64'(0));

    // Reset with 3 transactions in flight
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = 32'h0000_0010 + 32'(i);
      b        = 32'h0000_0001;
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_d", 64'(d), 64'(0));
    chk("midrst_bout", 64'(bout), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    rst_n     = 1'b1;
    out_ready = 1'b1;
    extra     = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("midrst_no_stale", 64'(extra), 64'(0));
    tick();
    single(32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
